// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM MEM-stage controller.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int SRAM_ADDR_W       = 18;
    localparam int SRAM_DATA_W       = 16;
    localparam int DEFAULT_BASE_ADDR = 1024;

    // 32-bit word index inside the SRAM; wraps modulo the SRAM size.
    function automatic logic [SRAM_ADDR_W-2:0] word_index(
        input logic [31:0] addr,
        input logic [31:0] base
    );
        return (SRAM_ADDR_W-1)'((addr - base) >> 2);
    endfunction

endpackage

// File: rtl/sram_perf_counter.sv
// Access and stall counters for the SRAM controller (used under SRAM_PERF_CNT_EN).
module sram_perf_counter (
    input  logic        clk,
    input  logic        rst,
    input  logic        access_start,
    input  logic        stall,
    output logic [31:0] access_count,
    output logic [31:0] stall_count
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            access_count <= 32'd0;
            stall_count  <= 32'd0;
        end else begin
            if (access_start) begin
                access_count <= access_count + 32'd1;
            end
            if (stall) begin
                stall_count <= stall_count + 32'd1;
            end
        end
    end

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage controller: one 32-bit access as two 16-bit asynchronous SRAM cycles.
// Optional perf counters are built when SRAM_PERF_CNT_EN is defined.
module sram_mem_controller
    import sram_pkg::*;
#(
    parameter int BASE_ADDR   = DEFAULT_BASE_ADDR,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
`ifdef SRAM_PERF_CNT_EN
    ,
    output logic [31:0]            access_count,
    output logic [31:0]            stall_count
`endif
);

    localparam logic [3:0] CNT_LAST = 4'(WAIT_CYCLES - 1);

    state_t                   state_reg;
    logic [3:0]               cnt_reg;
    logic                     op_write_reg;
    logic [SRAM_ADDR_W-2:0]   word_reg;
    logic [SRAM_DATA_W-1:0]   wdata_hi_reg;
    logic [31:0]              read_data_reg;
    logic [SRAM_ADDR_W-1:0]   sram_addr_reg;
    logic                     we_n_reg;
    logic                     oe_n_reg;
    logic [SRAM_DATA_W-1:0]   dq_out_reg;
    logic                     dq_en_reg;

    logic request;
    logic half_done;
    logic [SRAM_ADDR_W-2:0] word_next;

    assign request   = rd_en | wr_en;
    assign half_done = (cnt_reg == CNT_LAST);
    assign word_next = word_index(address, 32'(BASE_ADDR));

    always_comb begin
        ready = 1'b0;
        case (state_reg)
            IDLE:    ready = ~request;
            DONE:    ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Bus outputs are registered so they change only on the state transition edges.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= IDLE;
            cnt_reg       <= 4'd0;
            op_write_reg  <= 1'b0;
            word_reg      <= '0;
            wdata_hi_reg  <= '0;
            read_data_reg <= 32'd0;
            sram_addr_reg <= '0;
            we_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            dq_out_reg    <= '0;
            dq_en_reg     <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (request) begin
                        op_write_reg  <= wr_en;
                        word_reg      <= word_next;
                        wdata_hi_reg  <= write_data[31:16];
                        cnt_reg       <= 4'd0;
                        sram_addr_reg <= {word_next, 1'b0};
                        we_n_reg      <= ~wr_en;
                        oe_n_reg      <= wr_en;
                        dq_out_reg    <= write_data[15:0];
                        dq_en_reg     <= wr_en;
                        state_reg     <= LOW;
                    end
                end
                LOW: begin
                    if (half_done) begin
                        if (!op_write_reg) begin
                            read_data_reg[15:0] <= SRAM_DQ;
                        end
                        cnt_reg       <= 4'd0;
                        sram_addr_reg <= {word_reg, 1'b1};
                        dq_out_reg    <= wdata_hi_reg;
                        state_reg     <= HIGH;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                HIGH: begin
                    if (half_done) begin
                        if (!op_write_reg) begin
                            read_data_reg[31:16] <= SRAM_DQ;
                        end
                        cnt_reg   <= 4'd0;
                        we_n_reg  <= 1'b1;
                        oe_n_reg  <= 1'b1;
                        dq_en_reg <= 1'b0;
                        state_reg <= DONE;
                    end else begin
                        cnt_reg <= cnt_reg + 4'd1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign read_data = read_data_reg;
    assign SRAM_ADDR = sram_addr_reg;
    assign SRAM_WE_N = we_n_reg;
    assign SRAM_OE_N = oe_n_reg;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_DQ   = dq_en_reg ? dq_out_reg : {SRAM_DATA_W{1'bz}};

`ifdef SRAM_PERF_CNT_EN
    sram_perf_counter u_perf (
        .clk          (clk),
        .rst          (rst),
        .access_start ((state_reg == IDLE) && request),
        .stall        (~ready),
        .access_count (access_count),
        .stall_count  (stall_count)
    );
`endif

endmodule

// File: doc/sram_mem_controller.md
Name: sram_mem_controller

Overview:
- MEM-stage controller between the pipeline's data-memory request (MEM_R_En/MEM_W_En, ALU address, store data) and an external 256K x 16 asynchronous SRAM.
- Splits each 32-bit access into two 16-bit SRAM cycles.
- Produces `ready`; the pipeline drives superStall = ~ready into every stage register, including the ID/EX register, so this block is the producer of the stall that those registers consume.

Parameters:
- BASE_ADDR, 1024: CPU byte address mapped to SRAM word 0.
- WAIT_CYCLES, 2: clock cycles each 16-bit half-access is held on the SRAM pins (legal range 1..15).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-low reset.
- wr_en  input  1  store request (MEM_W_En).
- rd_en  input  1  load request (MEM_R_En).
- address  input  32  CPU byte address.
- write_data  input  32  store data.
- read_data  output  32  load data; registered.
- ready  output  1  access complete or no access pending; pipeline uses ~ready as superStall.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  output  18  SRAM halfword address.
- SRAM_WE_N  output  1  write enable, active-low.
- SRAM_OE_N  output  1  output enable, active-low.
- SRAM_CE_N  output  1  chip enable, tied 0.
- SRAM_UB_N  output  1  upper-byte enable, tied 0.
- SRAM_LB_N  output  1  lower-byte enable, tied 0.

Behaviour:
- States: IDLE, LOW, HIGH, DONE. A 4-bit wait counter `cnt` and a latched op bit (write or read).
- Reset (rst=0, asynchronous) forces:
  - state=IDLE, cnt=0, read_data=0;
  - SRAM_WE_N=1, SRAM_OE_N=1, SRAM_ADDR=0, SRAM_DQ=Z.
  - Reset mid-access abandons the access immediately. No partial read_data update.
- Request = rd_en | wr_en. If both are high, the write wins.
- Word index = (address - BASE_ADDR) >> 2, truncated to 17 bits. There is no range check; out-of-range addresses wrap modulo the SRAM size.
- IDLE:
  - ready = ~request (combinational).
  - On a request, latch word index, write_data and op; set cnt=0; go to LOW.
- LOW:
  - SRAM_ADDR = {word,1'b0}.
  - Write: SRAM_WE_N=0 and SRAM_DQ = write_data[15:0].
  - Read: SRAM_OE_N=0 and SRAM_DQ=Z.
  - cnt increments each cycle. When cnt==WAIT_CYCLES-1, a read captures SRAM_DQ into read_data[15:0]; then cnt=0 and go to HIGH.
- HIGH:
  - Same as LOW, using SRAM_ADDR = {word,1'b1} and data bits [31:16].
  - When cnt==WAIT_CYCLES-1, capture read_data[31:16] (read only) and go to DONE.
- DONE:
  - ready=1; SRAM_WE_N=1, SRAM_OE_N=1, SRAM_DQ=Z; go to IDLE unconditionally.
  - The pipeline advances on this edge, so the request seen in IDLE on the next cycle belongs to the next instruction.
- Latency: request first seen in cycle 0 → ready=1 in cycle 2*WAIT_CYCLES+1. With WAIT_CYCLES=2, ready=0 for cycles 0..4 and ready=1 in cycle 5.
- read_data holds its value until the next read's captures. Writes never modify read_data.
- Between halves, SRAM_WE_N is deasserted for zero cycles; the address change alone delimits the two halves.
- DQ is driven only in write LOW/HIGH states. DQ is never driven while SRAM_OE_N=0.

Optional Feature:
- Macro SRAM_PERF_CNT_EN.
- Defined: adds outputs access_count[31:0] and stall_count[31:0].
  - access_count increments on each IDLE→LOW transition.
  - stall_count increments every cycle ready=0.
  - Both reset to 0 and wrap at 2^32.
- Undefined: these ports and registers do not exist; all other behaviour is identical.

Decomposition:
- Shared package sram_pkg holds:
  - state enum {IDLE, LOW, HIGH, DONE};
  - SRAM_ADDR_W=18, SRAM_DATA_W=16, DEFAULT_BASE_ADDR=1024.
- One sub-module, sram_perf_counter, instantiated only under SRAM_PERF_CNT_EN. The rest is a single FSM module.

Test Plan:
- Reset check: rst=0 mid-LOW of a write → next sample shows state IDLE, SRAM_WE_N=1, DQ=Z, read_data=0, ready=1 with no request.
- Store: wr_en, address=1028, write_data=32'hDEADBEEF, WAIT_CYCLES=2 → SRAM_ADDR=2 with DQ=16'hBEEF for 2 cycles, then SRAM_ADDR=3 with DQ=16'hDEAD for 2 cycles; ready=0 for 5 cycles, then 1.
- Load: SRAM model holds word 1 = 32'h12345678; rd_en, address=1028 → read_data=32'h12345678 in the DONE cycle; SRAM_OE_N=0 for 4 cycles; DQ never driven by the DUT.
- Back-to-back: store then load to the same address in consecutive instructions → second access starts the cycle after DONE; load returns the stored value.
- Simultaneous rd_en=wr_en=1 → write performed and read_data unchanged. Address 1024+4*2^17 → SRAM_ADDR wraps to 0/1.
- SRAM_PERF_CNT_EN defined: two accesses with WAIT_CYCLES=2 → access_count=2, stall_count=10.
